timer_3ch: RTL and testbench
============================

// Module: timer_3ch
// PURPOSE
//  Three-channel 32-bit programmable timer (8253-style) that sits directly
//  downstream of the MIO bus decoder.
//  - Consumes counter_we and Peripheral_in from the ffffff04 window.
//  - Takes the channel select latched from the ffffff00 GPIO word.
//  - Returns counter_out and counter0/1/2_out to the bus read-back mux.
// PARAMETERS
//  PRESCALE  1   clk cycles per count tick (>=1); 1 = tick every clk
//  WIDTH     32  counter/reload width (bus data width)
// PORTS
//  clk            in   1      system clock; all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  counter_we     in   1      write strobe from bus decoder (1 clk)
//  counter_ch     in   2      00/01/10 = channel 0/1/2; 11 = control/status
//  counter_val    in   WIDTH  write data (Peripheral_in)
//  counter_out    out  WIDTH  read-back: count of selected ch, or status
//  counter0_out   out  1      channel 0 output
//  counter1_out   out  1      channel 1 output
//  counter2_out   out  1      channel 2 output
// BEHAVIOUR
//  Reset (sync, overrides all)
//  - All count, reload, mode and gate are 0. Outputs are 0.
//  - Prescaler is 0. Channels are idle.
//  Tick
//  - Prescaler counts 0..PRESCALE-1 on every clk.
//  - tick=1 for one clk when the prescaler equals PRESCALE-1, then it wraps to 0.
//  Load write (counter_we, ch=0..2)
//  - In the next cycle: R<=val, C<=val, out<=0, running<=(val!=0)&gate.
//  - val==0 stops the channel: C=0, out=0.
//  Control write (counter_we, ch=11)
//  - Fields: val[1:0]=target channel (11 = ignored), val[3:2]=mode, val[4]=gate.
//  - Target channel: C<=R, out<=0, running<=(R!=0)&gate. Takes effect next cycle.
//  Per-channel count, on tick while running:
//  - MODE 00 one-shot: C!=1 -> C-1. C==1 -> C<=0, out<=1 (sticky), running<=0.
//  - MODE 01 rate: C!=1 -> C-1, out<=0. C==1 -> C<=R, out<=1 for exactly one clk.
//  - MODE 10 square: C!=1 -> C-1. C==1 -> C<=R, out<=~out. Period = 2R ticks.
//  - MODE 11 hold: C and out frozen. running is unchanged.
//  Not running, or no tick
//  - C and out hold.
//  - Exception, MODE 01: out is 0 in any cycle that has no terminal event.
//  Simultaneous events
//  - A write to a channel in the same cycle as its terminal tick: the write wins.
//  - The tick is lost for that channel only.
//  Read-back (combinational mux)
//  - ch=0..2: counter_out = C of that channel.
//  - ch=11: counter_out = {26'b0, running[2:0], out[2:0]}.
//  Arithmetic
//  - Unsigned WIDTH-bit. Decrement never passes below 0.
//  - R=1 gives a terminal event every tick.
//  Reset mid-count
//  - Channel returns idle at once. No out pulse is generated.
// STRUCTURE
//  - Shared package timer_pkg: MODE_ONESHOT=2'b00, MODE_RATE=2'b01,
//    MODE_SQUARE=2'b10, MODE_HOLD=2'b11, CH_CTRL=2'b11, ctrl field offsets.
//  - Sub-module timer_channel (R, C, mode, gate, running, out), instantiated 3x.
//  - Top level holds the prescaler, write decode and read-back mux.
// TESTING
//  1 rst=1 two clks -> all outputs 0, counter_out=0 for every ch; rst mid-count
//    with C=5 -> C=0, out=0 next clk.
//  2 PRESCALE=1, ch0 ctrl val=0x10 (mode 00, gate=1), load ch0=3 -> out0 rises
//    exactly 3 clks after load takes effect, then stays 1; C=0, running0=0.
//  3 ch1 mode 01 gate=1, load 4 -> out1 is a 1-clk pulse every 4 clks;
//    counter_out(ch=01) sequence 4,3,2,1,4...
//  4 ch2 mode 10 gate=1, load 2 -> out2 toggles every 2 clks (period 4);
//    mode 11 written mid-run -> out2 and C frozen.
//  5 PRESCALE=4, ch0 rate mode, load 2 -> pulse every 8 clks; reload write on
//    the terminal tick -> no pulse, C=new value.
//  6 load 0 to a running channel -> running=0, out=0, C=0; status read
//    (ch=11) matches {running, out} bits.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared mode encodings, channel-select codes and control-word layout for the
// three-channel programmable timer.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RATE    = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    localparam logic [1:0] CH_CTRL = 2'b11;

    localparam int CTRL_TARGET_LSB = 0;
    localparam int CTRL_MODE_LSB   = 2;
    localparam int CTRL_GATE_BIT   = 4;
    localparam int CTRL_W          = 5;

    // Packed view of counter_val[4:0] on a control write: {gate, mode, target}.
    typedef struct packed {
        logic       gate;
        mode_e      mode;
        logic [1:0] target;
    } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload and count registers, mode, gate and output logic.
// Writes from the bus take priority over a coincident count tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic             i_ctrl,
    input  logic [WIDTH-1:0] i_val,
    input  mode_e            i_mode,
    input  logic             i_gate,
    output logic [WIDTH-1:0] o_count,
    output logic             o_out,
    output logic             o_running
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_count;
    mode_e            r_mode;
    logic             r_gate;
    logic             r_running;
    logic             r_out;

    // NOTE: every register here is updated with <= so all channels and the
    // prescaler see the same pre-edge values within a clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload  <= '0;
            r_count   <= '0;
            r_mode    <= MODE_ONESHOT;
            r_gate    <= 1'b0;
            r_running <= 1'b0;
            r_out     <= 1'b0;
        end else if (i_load) begin
            r_reload  <= i_val;
            r_count   <= i_val;
            r_out     <= 1'b0;
            r_running <= (i_val != '0) && r_gate;
        end else if (i_ctrl) begin
            r_mode    <= i_mode;
            r_gate    <= i_gate;
            r_count   <= r_reload;
            r_out     <= 1'b0;
            r_running <= (r_reload != '0) && i_gate;
        end else begin
            // Rate mode output is a single-cycle pulse; clear it unless a
            // terminal event below sets it again.
            if (r_mode == MODE_RATE) begin
                r_out <= 1'b0;
            end
            if (i_tick && r_running) begin
                case (r_mode)
                    MODE_ONESHOT: begin
                        if (r_count == ONE) begin
                            r_count   <= '0;
                            r_out     <= 1'b1;
                            r_running <= 1'b0;
                        end else if (r_count != '0) begin
                            r_count <= r_count - ONE;
                        end
                    end
                    MODE_RATE: begin
                        if (r_count == ONE) begin
                            r_count <= r_reload;
                            r_out   <= 1'b1;
                        end else if (r_count != '0) begin
                            r_count <= r_count - ONE;
                        end
                    end
                    MODE_SQUARE: begin
                        if (r_count == ONE) begin
                            r_count <= r_reload;
                            r_out   <= ~r_out;
                        end else if (r_count != '0) begin
                            r_count <= r_count - ONE;
                        end
                    end
                    MODE_HOLD: begin
                        r_count <= r_count;
                    end
                endcase
            end
        end
    end

    assign o_count   = r_count;
    assign o_out     = r_out;
    assign o_running = r_running;

endmodule

// File: rtl/timer_3ch.sv
// Three-channel programmable timer: shared prescaler, bus write decode and a
// combinational read-back mux over the channel counts and status bits.
module timer_3ch
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             counter_we,
    input  logic [1:0]       counter_ch,
    input  logic [WIDTH-1:0] counter_val,
    output logic [WIDTH-1:0] counter_out,
    output logic             counter0_out,
    output logic             counter1_out,
    output logic             counter2_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_prescale;
    logic             w_tick;
    ctrl_t            w_ctrl_word;
    logic             w_is_ctrl;
    logic [2:0]       w_load;
    logic [2:0]       w_ctrl;
    logic [2:0]       w_out;
    logic [2:0]       w_running;
    logic [WIDTH-1:0] w_count [3];

    assign w_tick = (r_prescale == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PW'(1);
        end
    end

    assign w_ctrl_word = ctrl_t'(counter_val[CTRL_W-1:0]);
    assign w_is_ctrl   = counter_we && (counter_ch == CH_CTRL);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        // A control word targeting CH_CTRL matches no channel and is dropped.
        assign w_load[i] = counter_we && (counter_ch == 2'(i));
        assign w_ctrl[i] = w_is_ctrl && (w_ctrl_word.target == 2'(i));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_load    (w_load[i]),
            .i_ctrl    (w_ctrl[i]),
            .i_val     (counter_val),
            .i_mode    (w_ctrl_word.mode),
            .i_gate    (w_ctrl_word.gate),
            .o_count   (w_count[i]),
            .o_out     (w_out[i]),
            .o_running (w_running[i])
        );
    end

    // NOTE: counter_out gets a default before the case so no path leaves it
    // unassigned and a latch cannot be inferred.
    always_comb begin
        counter_out = '0;
        case (counter_ch)
            2'b00:   counter_out = w_count[0];
            2'b01:   counter_out = w_count[1];
            2'b10:   counter_out = w_count[2];
            default: counter_out[5:0] = {w_running, w_out};
        endcase
    end

    assign counter0_out = w_out[0];
    assign counter1_out = w_out[1];
    assign counter2_out = w_out[2];

endmodule

// File: tb/tb_timer_3ch.sv
// Directed bench for timer_3ch: one instance at PRESCALE=1 and one at
// PRESCALE=4, expectations queued as stimulus is applied and popped on compare.
module tb_timer_3ch;

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic        we1, we4;
    logic [1:0]  ch1, ch4;
    logic [31:0] val1, val4;
    logic [31:0] out1, out4;
    logic        o10, o11, o12, o40, o41, o42;
    logic [31:0] v;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    timer_3ch #(.PRESCALE(1), .WIDTH(32)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .counter_we   (we1),
        .counter_ch   (ch1),
        .counter_val  (val1),
        .counter_out  (out1),
        .counter0_out (o10),
        .counter1_out (o11),
        .counter2_out (o12)
    );

    timer_3ch #(.PRESCALE(4), .WIDTH(32)) u_dut4 (
        .clk          (clk),
        .rst          (rst4),
        .counter_we   (we4),
        .counter_ch   (ch4),
        .counter_val  (val4),
        .counter_out  (out4),
        .counter0_out (o40),
        .counter1_out (o41),
        .counter2_out (o42)
    );

    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expected value queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [1:0] c, input logic [31:0] d);
        we1 = 1'b1; ch1 = c; val1 = d;
        step1();
        we1 = 1'b0;
    endtask

    task automatic wr4(input logic [1:0] c, input logic [31:0] d);
        we4 = 1'b1; ch4 = c; val4 = d;
        step1();
        we4 = 1'b0;
    endtask

    task automatic rd1(input logic [1:0] c, output logic [31:0] d);
        ch1 = c;
        #1;
        d = out1;
    endtask

    task automatic rd4(input logic [1:0] c, output logic [31:0] d);
        ch4 = c;
        #1;
        d = out4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; rst4 = 1'b1;
        we1 = 1'b0; we4 = 1'b0;
        ch1 = 2'b00; ch4 = 2'b00;
        val1 = '0; val4 = '0;

        // Reset state
        step1();
        step1();
        push("rst_outs", 32'h0);
        compare(32'({o12, o11, o10}));
        for (int c = 0; c < 4; c++) begin
            push($sformatf("rst_rd_ch%0d", c), 32'h0);
            rd1(2'(c), v);
            compare(v);
        end
        rst = 1'b0;

        // One-shot on ch0, load 3
        wr1(2'b11, 32'h10);
        wr1(2'b00, 32'd3);
        push("os_load_c", 32'd3);
        rd1(2'b00, v);
        compare(v);
        for (int k = 1; k <= 5; k++) begin
            step1();
            push($sformatf("os_c_k%0d", k), (k >= 3) ? 32'd0 : 32'(3 - k));
            rd1(2'b00, v);
            compare(v);
            push($sformatf("os_out_k%0d", k), (k >= 3) ? 32'd1 : 32'd0);
            compare(32'(o10));
        end
        push("os_status", 32'h01);
        rd1(2'b11, v);
        compare(v);

        // Rate on ch1, load 4
        wr1(2'b11, 32'h15);
        wr1(2'b01, 32'd4);
        push("rate_load_c", 32'd4);
        rd1(2'b01, v);
        compare(v);
        for (int k = 1; k <= 8; k++) begin
            step1();
            push($sformatf("rate_c_k%0d", k), (k % 4 == 0) ? 32'd4 : 32'(4 - (k % 4)));
            rd1(2'b01, v);
            compare(v);
            push($sformatf("rate_out_k%0d", k), (k % 4 == 0) ? 32'd1 : 32'd0);
            compare(32'(o11));
        end

        // Square on ch2, load 2, then hold
        wr1(2'b11, 32'h1A);
        wr1(2'b10, 32'd2);
        for (int k = 1; k <= 6; k++) begin
            step1();
            push($sformatf("sq_c_k%0d", k), (k % 2 == 1) ? 32'd1 : 32'd2);
            rd1(2'b10, v);
            compare(v);
            push($sformatf("sq_out_k%0d", k), 32'((k / 2) % 2));
            compare(32'(o12));
        end
        wr1(2'b11, 32'h1E);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step1();
            push($sformatf("hold_c_k%0d", k), 32'd2);
            rd1(2'b10, v);
            compare(v);
            push($sformatf("hold_out_k%0d", k), 32'd0);
            compare(32'(o12));
        end

        // Load 0 stops running ch1; status reflects running/out bits
        wr1(2'b01, 32'd0);
        push("stop_c", 32'd0);
        rd1(2'b01, v);
        compare(v);
        push("stop_out", 32'd0);
        compare(32'(o11));
        push("stop_status", 32'h21);
        rd1(2'b11, v);
        compare(v);
        step1();
        step1();
        push("stop_status_later", 32'h21);
        rd1(2'b11, v);
        compare(v);

        // Reset mid-count
        wr1(2'b01, 32'd5);
        push("midrst_c_before", 32'd5);
        rd1(2'b01, v);
        compare(v);
        rst = 1'b1;
        step1();
        push("midrst_c", 32'd0);
        rd1(2'b01, v);
        compare(v);
        push("midrst_outs", 32'd0);
        compare(32'({o12, o11, o10}));
        push("midrst_status", 32'd0);
        rd1(2'b11, v);
        compare(v);
        rst = 1'b0;

        // PRESCALE=4 rate on ch0, load 2; ticks land on every 4th edge after load+2
        step1();
        rst4 = 1'b0;
        wr4(2'b11, 32'h14);
        wr4(2'b00, 32'd2);
        push("p4_load_c", 32'd2);
        rd4(2'b00, v);
        compare(v);
        push("p4_other_outs", 32'd0);
        compare(32'({o42, o41}));
        for (int k = 1; k <= 13; k++) begin
            step1();
            n = (k >= 2) ? ((k - 2) / 4 + 1) : 0;
            push($sformatf("p4_c_k%0d", k), (n % 2 == 0) ? 32'd2 : 32'd1);
            rd4(2'b00, v);
            compare(v);
            push($sformatf("p4_out_k%0d", k),
                 (n > 0 && n % 2 == 0 && (k - 2) % 4 == 0) ? 32'd1 : 32'd0);
            compare(32'(o40));
        end
        // Write lands on the terminal tick: no pulse, new value loaded
        wr4(2'b00, 32'd7);
        push("p4_wr_tt_c", 32'd7);
        rd4(2'b00, v);
        compare(v);
        push("p4_wr_tt_out", 32'd0);
        compare(32'(o40));
        for (int k = 15; k <= 18; k++) begin
            step1();
            push($sformatf("p4_after_c_k%0d", k), (k == 18) ? 32'd6 : 32'd7);
            rd4(2'b00, v);
            compare(v);
            push($sformatf("p4_after_out_k%0d", k), 32'd0);
            compare(32'(o40));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
